// File: rtl/regfile_wb_sequencer.sv
// regfile_wb_sequencer: in-order writeback FIFO feeding the register file write port, with bypass lookup
module regfile_wb_sequencer #(
   parameter int XLEN  = 64,
   parameter int AW    = 6,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       alu_valid,
   output logic                       alu_ready,
   input  logic [AW-1:0]              alu_rd,
   input  logic [XLEN-1:0]            alu_data,
   input  logic                       mem_valid,
   output logic                       mem_ready,
   input  logic [AW-1:0]              mem_rd,
   input  logic [XLEN-1:0]            mem_data,
   input  logic                       wb_hold,
   output logic                       RegWrite,
   output logic [AW-1:0]              rd,
   output logic [XLEN-1:0]            wrt_data,
   input  logic [AW-1:0]              byp_rs1,
   input  logic [AW-1:0]              byp_rs2,
   output logic                       byp_hit1,
   output logic                       byp_hit2,
   output logic [XLEN-1:0]            byp_data1,
   output logic [XLEN-1:0]            byp_data2,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH)+1:0]   pending
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [AW-1:0]   q_rd   [DEPTH];
   logic [XLEN-1:0] q_data [DEPTH];
   logic [PW-1:0]   head, tail;
   logic [CW-1:0]   count;
   logic            acc_mem, acc_alu, push, pop;
   logic [AW-1:0]   in_rd;
   logic [XLEN-1:0] in_data;
   assign full      = count == CW'(DEPTH);
   assign empty     = count == '0 && !RegWrite;
   assign pending   = {1'b0, count} + {{CW{1'b0}}, RegWrite};
   assign mem_ready = !full;
   assign alu_ready = !full && !mem_valid;
   assign acc_mem   = mem_valid && mem_ready;
   assign acc_alu   = alu_valid && alu_ready;
   assign in_rd     = acc_mem ? mem_rd : alu_rd;
   assign in_data   = acc_mem ? mem_data : alu_data;
   // writes to x0 finish the handshake but never occupy a slot
   assign push      = (acc_mem || acc_alu) && in_rd != '0;
   assign pop       = !wb_hold && count != '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         RegWrite <= 1'b0;
         rd       <= '0;
         wrt_data <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop) head <= head + PW'(1);
         count    <= count + CW'(push) - CW'(pop);
         RegWrite <= pop;
         if (pop) begin
            rd       <= q_rd[head];
            wrt_data <= q_data[head];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[tail]   <= in_rd;
         q_data[tail] <= in_data;
      end
   end
   // output register is oldest; later FIFO matches (younger) override
   always_comb begin
      byp_hit1  = RegWrite && rd == byp_rs1 && byp_rs1 != '0;
      byp_hit2  = RegWrite && rd == byp_rs2 && byp_rs2 != '0;
      byp_data1 = byp_hit1 ? wrt_data : '0;
      byp_data2 = byp_hit2 ? wrt_data : '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count && q_rd[head + PW'(i)] == byp_rs1 && byp_rs1 != '0) begin
            byp_hit1  = 1'b1;
            byp_data1 = q_data[head + PW'(i)];
         end
         if (CW'(i) < count && q_rd[head + PW'(i)] == byp_rs2 && byp_rs2 != '0) begin
            byp_hit2  = 1'b1;
            byp_data2 = q_data[head + PW'(i)];
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// tb_regfile_wb_sequencer: directed vectors plus random traffic checked against a queue-based model
module tb_regfile_wb_sequencer;
   logic        clk = 0, rst_n = 0;
   logic        alu_valid = 0, mem_valid = 0, wb_hold = 0;
   logic        alu_ready, mem_ready, RegWrite, byp_hit1, byp_hit2, full, empty;
   logic [5:0]  alu_rd = 0, mem_rd = 0, rd, byp_rs1 = 0, byp_rs2 = 0;
   logic [63:0] alu_data = 0, mem_data = 0, wrt_data, byp_data1, byp_data2;
   logic [3:0]  pending;
   int errs = 0, checks = 0, zero_writes = 0;

   regfile_wb_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .wb_hold(wb_hold), .RegWrite(RegWrite), .rd(rd), .wrt_data(wrt_data),
      .byp_rs1(byp_rs1), .byp_rs2(byp_rs2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
      .byp_data1(byp_data1), .byp_data2(byp_data2),
      .full(full), .empty(empty), .pending(pending)
   );

   always #5 clk = ~clk;

   logic [63:0] rf [64];
   always @(posedge clk) begin
      if (RegWrite) rf[rd] <= wrt_data;
      if (RegWrite && rd == 0) zero_writes <= zero_writes + 1;
   end

   typedef struct packed {logic [5:0] r; logic [63:0] d;} ent_t;
   ent_t        q[$];
   logic        m_we = 0, m_acc_alu = 0, m_acc_mem = 0;
   logic [5:0]  m_rd = 0;
   logic [63:0] m_data = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_byp(input logic [5:0] rs, output logic h, output logic [63:0] d);
      h = 0;
      d = 0;
      if (rs != 0) begin
         if (m_we && m_rd == rs) begin h = 1; d = m_data; end
         foreach (q[i]) if (q[i].r == rs) begin h = 1; d = q[i].d; end
      end
   endtask

   task automatic check_model();
      logic h1, h2, f;
      logic [63:0] d1, d2;
      model_byp(byp_rs1, h1, d1);
      model_byp(byp_rs2, h2, d2);
      f = q.size() == 4;
      chk("ctrl", 128'({alu_ready, mem_ready, full, empty, pending, RegWrite, rd}),
          128'({!f && !mem_valid, !f, f, q.size() == 0 && !m_we, 4'(q.size() + int'(m_we)), m_we, m_rd}));
      chk("wdata", 128'(wrt_data), 128'(m_data));
      chk("byp1", 128'({byp_hit1, byp_data1}), 128'({h1, d1}));
      chk("byp2", 128'({byp_hit2, byp_data2}), 128'({h2, d2}));
   endtask

   task automatic model_edge();
      ent_t e;
      logic f;
      f = q.size() == 4;
      m_acc_mem = mem_valid && !f;
      m_acc_alu = alu_valid && !f && !mem_valid;
      if (!wb_hold && q.size() > 0) begin
         e = q.pop_front();
         m_we = 1; m_rd = e.r; m_data = e.d;
      end else m_we = 0;
      if (m_acc_mem && mem_rd != 0) q.push_back({mem_rd, mem_data});
      else if (m_acc_alu && alu_rd != 0) q.push_back({alu_rd, alu_data});
   endtask

   task automatic model_clear();
      q.delete();
      m_we = 0; m_rd = 0; m_data = 0; m_acc_alu = 0; m_acc_mem = 0;
   endtask

   task automatic cycle();
      #1;
      check_model();
      model_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      alu_valid = 0; mem_valid = 0; wb_hold = 0; byp_rs1 = 0; byp_rs2 = 0;
      rst_n = 0;
      model_clear();
      @(posedge clk);
      #1 rst_n = 1;
      #1;
   endtask

   typedef struct {logic av; logic [5:0] r; logic h; logic rdy; logic f; logic [3:0] p; logic we; logic [5:0] o;} vec_t;
   vec_t tv[13];

   initial begin
      tv[0]  = '{1, 1, 1, 1, 0, 0, 0, 0};
      tv[1]  = '{1, 2, 1, 1, 0, 1, 0, 0};
      tv[2]  = '{1, 3, 1, 1, 0, 2, 0, 0};
      tv[3]  = '{1, 4, 1, 1, 0, 3, 0, 0};
      tv[4]  = '{1, 5, 1, 0, 1, 4, 0, 0};
      tv[5]  = '{1, 5, 1, 0, 1, 4, 0, 0};
      tv[6]  = '{1, 5, 0, 0, 1, 4, 0, 0};
      tv[7]  = '{1, 5, 0, 1, 0, 4, 1, 1};
      tv[8]  = '{0, 5, 0, 1, 0, 4, 1, 2};
      tv[9]  = '{0, 5, 0, 1, 0, 3, 1, 3};
      tv[10] = '{0, 5, 0, 1, 0, 2, 1, 4};
      tv[11] = '{0, 5, 0, 1, 0, 1, 1, 5};
      tv[12] = '{0, 5, 0, 1, 0, 0, 0, 5};

      do_reset();
      chk("reset", 128'({RegWrite, rd, wrt_data, full, empty, pending, alu_ready, mem_ready, byp_hit1, byp_hit2}),
          128'({1'b0, 6'd0, 64'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0}));

      // single ALU write and its latency
      alu_valid = 1; alu_rd = 5; alu_data = 64'hAAAA_BBBB_CCCC_DDDD; byp_rs1 = 5;
      cycle();
      alu_valid = 0;
      #1;
      chk("t1_byp", 128'({byp_hit1, byp_data1, RegWrite}), 128'({1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0}));
      cycle();
      chk("t1_we", 128'({RegWrite, rd, wrt_data}), 128'({1'b1, 6'd5, 64'hAAAA_BBBB_CCCC_DDDD}));
      cycle();
      chk("t1_rf", 128'({RegWrite, rf[5]}), 128'({1'b0, 64'hAAAA_BBBB_CCCC_DDDD}));

      // load priority over ALU
      do_reset();
      mem_valid = 1; mem_rd = 10; mem_data = 64'h1234_5678_9ABC_DEF0;
      alu_valid = 1; alu_rd = 11; alu_data = 64'd1;
      #1;
      chk("t2_arb", 128'({alu_ready, mem_ready}), 128'({1'b0, 1'b1}));
      cycle();
      mem_valid = 0;
      cycle();
      alu_valid = 0;
      chk("t2_first", 128'({RegWrite, rd}), 128'({1'b1, 6'd10}));
      cycle();
      chk("t2_second", 128'({RegWrite, rd, wrt_data}), 128'({1'b1, 6'd11, 64'd1}));
      cycle();
      chk("t2_rf", 128'({rf[10], rf[11]}), 128'({64'h1234_5678_9ABC_DEF0, 64'd1}));

      // hold, fill, stall and drain
      do_reset();
      for (int i = 0; i < 13; i++) begin
         alu_valid = tv[i].av; alu_rd = tv[i].r; alu_data = 64'(tv[i].r) << 8; wb_hold = tv[i].h;
         #1;
         chk($sformatf("t3_row%0d", i), 128'({alu_ready, full, pending, RegWrite, rd}),
             128'({tv[i].rdy, tv[i].f, tv[i].p, tv[i].we, tv[i].o}));
         cycle();
      end

      // bypass youngest-wins, miss and x0
      do_reset();
      wb_hold = 1; alu_valid = 1; alu_rd = 7; alu_data = 64'h11;
      cycle();
      alu_data = 64'h22;
      cycle();
      alu_valid = 0; byp_rs1 = 7; byp_rs2 = 8;
      #1;
      chk("t4_hit", 128'({byp_hit1, byp_data1}), 128'({1'b1, 64'h22}));
      chk("t4_miss", 128'({byp_hit2, byp_data2}), 128'({1'b0, 64'h0}));
      byp_rs1 = 0;
      #1;
      chk("t4_x0", 128'({byp_hit1, byp_data1}), 128'({1'b0, 64'h0}));
      wb_hold = 0; byp_rs1 = 7;
      repeat (4) cycle();

      // write to x0 is dropped
      do_reset();
      alu_valid = 1; alu_rd = 0; alu_data = '1;
      #1;
      chk("t5_ready", 128'(alu_ready), 128'(1'b1));
      cycle();
      alu_valid = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t5_idle", 128'({RegWrite, empty, pending}), 128'({1'b0, 1'b1, 4'd0}));
      end
      chk("t5_zero_writes", 128'(zero_writes), 128'(0));

      // asynchronous reset mid-drain
      do_reset();
      wb_hold = 1;
      for (int i = 1; i <= 4; i++) begin
         alu_valid = 1; alu_rd = 6'(i); alu_data = 64'(i);
         cycle();
      end
      alu_valid = 0; wb_hold = 0;
      cycle();
      chk("t6_pre", 128'({RegWrite, pending}), 128'({1'b1, 4'd4}));
      byp_rs1 = 3;
      #1 rst_n = 0;
      #1;
      chk("t6_rst", 128'({RegWrite, pending, empty, byp_hit1, rd, wrt_data}),
          128'({1'b0, 4'd0, 1'b1, 1'b0, 6'd0, 64'd0}));
      model_clear();
      @(posedge clk);
      #1 rst_n = 1;
      #1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t6_idle", 128'(RegWrite), 128'(1'b0));
      end

      // random traffic against the model
      do_reset();
      for (int n = 0; n < 800; n++) begin
         wb_hold = $urandom_range(0, 3) == 0;
         byp_rs1 = 6'($urandom_range(0, 9));
         byp_rs2 = 6'($urandom_range(0, 9));
         if (!alu_valid || m_acc_alu) begin
            alu_valid = $urandom_range(0, 1) == 1;
            alu_rd = 6'($urandom_range(0, 9));
            alu_data = {$urandom, $urandom};
         end
         if (!mem_valid || m_acc_mem) begin
            mem_valid = $urandom_range(0, 2) == 0;
            mem_rd = 6'($urandom_range(0, 9));
            mem_data = {$urandom, $urandom};
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
